// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter FSM states, oversample constants and parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam logic [3:0] OSR_LAST = 4'd15;
    localparam int unsigned DATA_BITS = 8;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side byte handshake into the UART transmitter.
interface uart_tx_if import uart_tx_pkg::*; ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
module uart_tx_fifo import uart_tx_pkg::*; #(
    parameter int unsigned AW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          level
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [DATA_BITS-1:0] mem [Depth];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first framing with optional parity, 1 or 2 stop bits, 16x tick timing.
module uart_tx import uart_tx_pkg::*; #(
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_16x,
    uart_tx_if.slave           bus,
    output logic               txd,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);
    localparam logic       StopLast = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [3:0]           osr_q, osr_d;
    logic [2:0]           bitpos_q, bitpos_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 txd_q, txd_d;
    logic                 armed_q;

    logic                 fifo_full, fifo_empty, push, pop, load, bit_end;
    logic [DATA_BITS-1:0] fifo_rd_data;

    // Ready is held low until the first clock after reset release.
    assign bus.tx_ready = armed_q && !fifo_full;
    assign push         = bus.tx_valid && bus.tx_ready;
    assign bit_end      = (osr_q == OSR_LAST);
    assign txd          = txd_q;
    assign tx_busy      = (state_q != S_IDLE) || (fifo_level != '0);

    uart_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (bus.tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        osr_d    = osr_q;
        bitpos_d = bitpos_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        stop_d   = stop_q;
        txd_d    = txd_q;
        load     = 1'b0;
        pop      = 1'b0;

        if (tick_16x) begin
            osr_d = osr_q + 4'd1;
            case (state_q)
                S_IDLE: begin
                    txd_d = 1'b1;
                    load  = !fifo_empty;
                end
                S_START: begin
                    if (bit_end) begin
                        txd_d    = shreg_q[0];
                        bitpos_d = '0;
                        state_d  = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bitpos_q == BitLast) begin
                            stop_d = 1'b0;
                            if (PARITY_EN != 0) begin
                                txd_d   = par_q;
                                state_d = S_PARITY;
                            end else begin
                                txd_d   = 1'b1;
                                state_d = S_STOP;
                            end
                        end else begin
                            shreg_d  = shreg_q >> 1;
                            txd_d    = shreg_q[1];
                            bitpos_d = bitpos_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        txd_d   = 1'b1;
                        stop_d  = 1'b0;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_q == StopLast) begin
                            // Chain straight into the next start bit when data is waiting.
                            load = !fifo_empty;
                            if (fifo_empty) begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            stop_d = 1'b1;
                        end
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = S_IDLE;
                end
            endcase

            if (load) begin
                pop     = 1'b1;
                shreg_d = fifo_rd_data;
                par_d   = calc_parity(fifo_rd_data, PARITY_ODD != 0);
                txd_d   = 1'b0;
                osr_d   = '0;
                state_d = S_START;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            osr_q    <= '0;
            bitpos_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            txd_q    <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            osr_q    <= osr_d;
            bitpos_q <= bitpos_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            txd_q    <= txd_d;
            armed_q  <= 1'b1;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, 8 data bits, LSB-first, optional parity, 1 or 2 stop bits, bit timing from the shared 16x oversample tick. It is the transmit-side counterpart of the lab UART receiver and pairs with it for loopback. With default parameters it is 8N1, so a `txd`→`rxd` loopback returns identical bytes. A small input FIFO, the `uart_tx_fifo` sub-module, decouples the producer and allows back-to-back frames with no idle gap.

## Interface
- `FIFO_AW`, 2: FIFO address width. Depth is 2**FIFO_AW; legal range 1..4.
- `PARITY_EN`, 0: 1 inserts one parity bit after data bit 7.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `clk` input 1: single system clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_16x` input 1: one-`clk` pulse at BAUD*16. The same source feeds the receiver.
- `tx_data` input 8: byte to send, bit 0 goes out first.
- `tx_valid` input 1: producer offers `tx_data` this cycle.
- `tx_ready` output 1: FIFO can accept a byte this cycle.
- `txd` output 1: serial line, registered, idle high.
- `tx_busy` output 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_level` output FIFO_AW+1: current FIFO occupancy, 0..2**FIFO_AW.

## Operation
- Write handshake: a byte is accepted when `tx_valid && tx_ready`.
  - `tx_ready` = !full, taken from registered level. Nothing is accepted while full.
  - Data is held in the FIFO; there is no combinational pass-through.
- FSM states: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
- Bit timing:
  - `osr_cnt` is 4 bits and counts `tick_16x` pulses 0..15.
  - A bit ends on the tick where `osr_cnt`==15; `osr_cnt` then wraps to 0.
- S_IDLE:
  - `txd`=1.
  - On a `tick_16x` cycle with the FIFO non-empty: pop the head into `shreg`, drive `txd`=0, clear `osr_cnt`, go to S_START.
  - Leaving idle only on a tick gives every bit exactly 16 tick periods.
- S_START: at bit end, `txd`=`shreg[0]`, `bitpos`=0, go to S_DATA.
- S_DATA:
  - At bit end, shift `shreg` right and increment `bitpos`.
  - After bit 7 ends, go to S_PARITY if `PARITY_EN`, else to S_STOP with `txd`=1.
- S_PARITY:
  - `txd` = XOR of the 8 data bits, XOR `PARITY_ODD`.
  - Parity is computed when the byte is loaded.
- S_STOP:
  - `txd`=1 for STOP_BITS*16 ticks, using `stop_cnt` to count stop bits.
  - At the final tick: if the FIFO is non-empty, pop and go directly to S_START with `txd`=0 on that same tick (zero idle gap). Otherwise go to S_IDLE.
- Illegal state: go to S_IDLE with `txd`=1.
- Simultaneous push and pop: allowed whenever not full. Level is unchanged; pointers both advance and wrap modulo depth.
- Push while empty: the byte is visible to the FSM on the next cycle, never the same cycle.
- `tx_busy` = (state != S_IDLE) || (`fifo_level` != 0).

## Timing
- Values while `rst_n`=0: `txd`=1, `tx_ready`=0, `tx_busy`=0, `fifo_level`=0, state S_IDLE, FIFO pointers 0.
  - `tx_ready` rises on the first `clk` after `rst_n` deasserts.
- Reset mid-frame: the line returns high immediately (asynchronously), the FIFO is emptied, and the partial frame is abandoned.
- Accept to start edge: if accepted at cycle N with the FSM idle, `txd` falls at the first `tick_16x` cycle at or after N+1, registered, so it is visible one `clk` later.
- Frame length in ticks: 16 × (1 + 8 + PARITY_EN + STOP_BITS). The 8N1 default is 160 ticks.
- `tick_16x` is ignored outside a valid tick cycle. The FSM changes state only on tick cycles, apart from reset.
- Continuous `tx_valid` with `tx_ready` high: the FIFO fills at one byte per `clk`, and `tx_ready` drops in the cycle after the level reaches depth.

## Structure
- Shared package or header `uart_pkg.vh` holds:
  - state localparams S_IDLE..S_STOP, with S_PARITY added;
  - OSR_LAST=4'd15;
  - DATA_BITS=8, reused by the receiver.
- Sub-module `uart_tx_fifo`: synchronous FIFO on `clk`/`rst_n`, parameter AW.
  - Ports: wr_en, wr_data, rd_en, rd_data (head, first-word-fall-through), full, empty, level.
  - Pointers are AW+1 bits wide; full/empty are derived from the MSB comparison.
- The top contains the FSM, `shreg`, the parity register and the `txd` register.

## Test plan
- Single 8N1 byte 0x55 after reset, tick every 4 clk → `txd` shows low, then 1,0,1,0,1,0,1,0, then high; each bit lasts 64 clk; `tx_busy` falls after the stop bit.
- Burst 0xA5, 0x3C, 0xFF, 0x00, 0x81 with depth 4 → `tx_ready` low after 4 accepts and the fifth is held until the first pop; frames are back-to-back with no idle gap; loopback into the receiver returns the same 5 bytes with no framing_error.
- `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07 → parity bit 1. With `PARITY_ODD`=1 → parity bit 0. Frame is 176 ticks.
- `STOP_BITS`=2 with two queued bytes → exactly 32 ticks high between the last data bit and the next start bit.
- `rst_n` asserted mid-S_DATA of byte 0x96 with 2 bytes queued → `txd` goes to 1 asynchronously and `fifo_level`=0; after release, no further frame is sent until a new write.
- Push and pop in the same cycle at level 2 → `fifo_level` stays 2; pointer wrap over 20 bytes preserves order.
